// File: rtl/cnn_pkg.sv
// Shared state encoding and constants for the CNN 3x3 window controller slice.
package cnn_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} cnn_win_state_e;

  localparam int CNN_KERNEL  = 3;
  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/cnn_window_ctrl_if.sv
// Pixel stream, line-buffer write and window handshake bundle for cnn_window_ctrl.
interface cnn_window_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28
);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  logic [DATA_WIDTH-1:0] s_pixel;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] lb_pixel;
  logic                  lb_wr_en;
  logic [COL_W-1:0]      lb_col;
  logic                  win_valid;
  logic                  win_ready;
  logic [ROW_W-1:0]      win_row;
  logic [COL_W-1:0]      win_col;

  // master is the controller's side; slave is the source/sink environment
  modport master (
    input  s_pixel, s_valid, win_ready,
    output s_ready, lb_pixel, lb_wr_en, lb_col, win_valid, win_row, win_col
  );

  modport slave (
    output s_pixel, s_valid, win_ready,
    input  s_ready, lb_pixel, lb_wr_en, lb_col, win_valid, win_row, win_col
  );
endinterface

// File: rtl/cnn_rc_counter.sv
// Raster row/column counter: advances on en, wraps column then row, flags the last pixel.
module cnn_rc_counter #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  output logic [$clog2(IMG_H)-1:0] row,
  output logic [$clog2(IMG_W)-1:0] col,
  output logic                     last
);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

  logic col_end;
  logic row_end;

  assign col_end = (col == COL_MAX);
  assign row_end = (row == ROW_MAX);
  assign last    = col_end && row_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end
endmodule

// File: rtl/cnn_window_ctrl.sv
// Frame sequencer for the 3x3 sliding-window datapath: raster tracking and window events.
// Optional backpressure stall counter is built when CNN_WIN_CTRL_STALL_CNT_EN is defined.
module cnn_window_ctrl
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int KERNEL     = CNN_KERNEL
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  cnn_window_ctrl_if.master      bus
);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [ROW_W-1:0] K_ROW = ROW_W'(KERNEL - 1);
  localparam logic [COL_W-1:0] K_COL = COL_W'(KERNEL - 1);

  cnn_win_state_e        state;
  logic [ROW_W-1:0]      row;
  logic [COL_W-1:0]      col;
  logic                  last;
  logic [DATA_WIDTH-1:0] pixel;
  logic                  win_valid_q;
  logic [ROW_W-1:0]      win_row_q;
  logic [COL_W-1:0]      win_col_q;
  logic                  start_acc;
  logic                  stall;
  logic                  s_ready;
  logic                  accept;
  logic                  win_hit;
  logic                  win_fire;

  assign start_acc = (state == IDLE) && start;
  assign stall     = win_valid_q && !bus.win_ready;
  assign s_ready   = (state == STREAM) && !stall;
  assign accept    = bus.s_valid && s_ready;
  assign win_hit   = accept && (row >= K_ROW) && (col >= K_COL);
  assign win_fire  = win_valid_q && bus.win_ready;
  assign pixel     = bus.s_pixel;

  assign bus.s_ready   = s_ready;
  assign bus.lb_pixel  = pixel;
  assign bus.lb_wr_en  = accept;
  assign bus.lb_col    = col;
  assign bus.win_valid = win_valid_q;
  assign bus.win_row   = win_row_q;
  assign bus.win_col   = win_col_q;

  cnn_rc_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_rc (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_acc),
    .en   (accept),
    .row  (row),
    .col  (col),
    .last (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      done <= 1'b0;
      // a fresh window may load in the same cycle the pending one is taken
      if (win_hit) begin
        win_valid_q <= 1'b1;
        win_row_q   <= row - K_ROW;
        win_col_q   <= col - K_COL;
      end else if (win_fire) begin
        win_valid_q <= 1'b0;
      end
      case (state)
        IDLE: if (start) begin
          state <= STREAM;
          busy  <= 1'b1;
        end
        STREAM: if (accept && last) state <= FLUSH;
        // the only window outstanding here is the frame's last one
        FLUSH: if (win_fire) begin
          state <= DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CNN_WIN_CTRL_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (start_acc) begin
      stall_q <= '0;
    end else if (stall && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif
endmodule
